// File: rtl/pipo_seq_ctrl_if.sv
// Handshake and strobe bundle around one img2col PIPO stage.
// master = the sequencer (pipo_seq_ctrl), slave = its upstream/downstream environment.
interface pipo_seq_ctrl_if;
    logic start;
    logic abort;
    logic in_valid;
    logic in_ready;
    logic out_ready;
    logic out_valid;
    logic wr_ctrl;
    logic r_ctrl;
    logic busy;
    logic done;

    modport master (
        input  start, abort, in_valid, out_ready,
        output in_ready, out_valid, wr_ctrl, r_ctrl, busy, done
    );

    modport slave (
        output start, abort, in_valid, out_ready,
        input  in_ready, out_valid, wr_ctrl, r_ctrl, busy, done
    );
endinterface

// File: rtl/pipo_seq_ctrl.sv
// Sequencer for one img2col PIPO stage: tracks PIPO registers (A) and PIPO out (B)
// as a 2-entry pipeline, NUM_VECS vectors per job. Define STALL_CNT_EN for stall_cnt.
module pipo_seq_ctrl #(
    parameter int NUM_VECS = 9
`ifdef STALL_CNT_EN
    ,
    parameter int STALL_W  = 16
`endif
) (
    input  logic            clk,
    input  logic            rst,
    pipo_seq_ctrl_if.master bus
`ifdef STALL_CNT_EN
    ,
    output logic [STALL_W-1:0] stall_cnt
`endif
);
    localparam int CNT_W = $clog2(NUM_VECS + 1);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(NUM_VECS);
    localparam logic [CNT_W-1:0] LAST_M1 = CNT_W'(NUM_VECS - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nxt;
    logic             a_full, a_full_nxt;
    logic             b_full, b_full_nxt;
    logic [CNT_W-1:0] in_cnt, in_cnt_nxt;
    logic [CNT_W-1:0] out_cnt, out_cnt_nxt;
    logic             done_q, done_nxt;

    logic run;
    logic c_fire;
    logic r_ctrl;
    logic in_ready;
    logic wr_ctrl;

    // Strobes settle after posedge; the PIPO samples them on the following negedge.
    always_comb begin
        run      = (state == RUN);
        c_fire   = b_full & bus.out_ready;
        r_ctrl   = run & a_full & (~b_full | c_fire);
        in_ready = run & (in_cnt < LAST) & (~a_full | r_ctrl);
        wr_ctrl  = bus.in_valid & in_ready;
    end

    always_comb begin
        state_nxt   = state;
        a_full_nxt  = a_full;
        b_full_nxt  = b_full;
        in_cnt_nxt  = in_cnt;
        out_cnt_nxt = out_cnt;
        done_nxt    = 1'b0;

        if (bus.abort) begin
            state_nxt   = IDLE;
            a_full_nxt  = 1'b0;
            b_full_nxt  = 1'b0;
            in_cnt_nxt  = '0;
            out_cnt_nxt = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        state_nxt   = RUN;
                        a_full_nxt  = 1'b0;
                        b_full_nxt  = 1'b0;
                        in_cnt_nxt  = '0;
                        out_cnt_nxt = '0;
                    end
                end
                RUN: begin
                    a_full_nxt = wr_ctrl | (a_full & ~r_ctrl);
                    b_full_nxt = r_ctrl | (b_full & ~c_fire);
                    if (wr_ctrl && in_cnt != LAST)
                        in_cnt_nxt = in_cnt + CNT_W'(1);
                    if (c_fire && out_cnt != LAST)
                        out_cnt_nxt = out_cnt + CNT_W'(1);
                    // Last consume ends the job; done is registered so it shows next cycle.
                    if (c_fire && out_cnt == LAST_M1) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            a_full  <= 1'b0;
            b_full  <= 1'b0;
            in_cnt  <= '0;
            out_cnt <= '0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            a_full  <= a_full_nxt;
            b_full  <= b_full_nxt;
            in_cnt  <= in_cnt_nxt;
            out_cnt <= out_cnt_nxt;
            done_q  <= done_nxt;
        end
    end

`ifdef STALL_CNT_EN
    // Survives abort so a flushed job's stalls remain visible until the next start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (state == IDLE && bus.start && !bus.abort)
            stall_cnt <= '0;
        else if (run && b_full && !bus.out_ready && stall_cnt != '1)
            stall_cnt <= stall_cnt + STALL_W'(1);
    end
`endif

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = b_full;
    assign bus.wr_ctrl   = wr_ctrl;
    assign bus.r_ctrl    = r_ctrl;
    assign bus.busy      = run;
    assign bus.done      = done_q;
endmodule
